cg_result_writeback: RTL and testbench

- Write-side sequencer for the CG solver datapath; the producing end of the result-write interface that the address control unit consumes.
- Buffers ALU result words in a small FIFO and drains one word per cycle into the X, R or P vector memory.
- Generates the per-memory write strobes and the write-word counter, and issues the read-again pulses that advance operand fetch.
- Signals phase completion once total/NO_OF_UNITS words are written.

---
 rtl/cg_result_writeback_if.sv | 62 ++++++
 rtl/cg_result_writeback.sv | 237 +++++++++++++++++++++++
 tb/tb_cg_result_writeback.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cg_result_writeback_if.sv
// Result-write bus between the CG ALU, the write-back sequencer and the
// X/R/P vector memories.
//
// Handshake rules:
//   ALU side: a beat transfers on a rising clk edge where alu_valid && alu_ready.
//     alu_ready is derived from registered state only and never looks at alu_valid.
//     alu_data is only meaningful while alu_valid is high.
//   Memory side: the sequencer pops one buffered word on a rising edge where the
//     buffer is non-empty and mem_ready is high. The write is presented on the
//     registered outputs during the following cycle: exactly one of
//     mem_we_x/r/p is high, with mem_wdata and mem_waddr. read_again
//     accompanies X writes and read_again_2 accompanies P writes.
//     With mem_ready low, nothing is popped and all strobes are low in the
//     next cycle.
interface cg_result_writeback_if #(
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 32
);
    localparam int W = NO_OF_UNITS * ELEMENT_WIDTH;

    logic          alu_valid;
    logic [W-1:0]  alu_data;
    logic          alu_ready;
    logic          mem_ready;
    logic [W-1:0]  mem_wdata;
    logic [31:0]   mem_waddr;
    logic          mem_we_x;
    logic          mem_we_r;
    logic          mem_we_p;
    logic          read_again;
    logic          read_again_2;

    // Write-back sequencer side: consumes ALU beats, produces memory writes.
    modport master (
        input  alu_valid,
        input  alu_data,
        output alu_ready,
        input  mem_ready,
        output mem_wdata,
        output mem_waddr,
        output mem_we_x,
        output mem_we_r,
        output mem_we_p,
        output read_again,
        output read_again_2
    );

    // ALU / memory / address-control side.
    modport slave (
        output alu_valid,
        output alu_data,
        input  alu_ready,
        output mem_ready,
        input  mem_wdata,
        input  mem_waddr,
        input  mem_we_x,
        input  mem_we_r,
        input  mem_we_p,
        input  read_again,
        input  read_again_2
    );
endinterface

// File: rtl/cg_result_writeback.sv
// cg_result_writeback: write-side sequencer of the CG solver datapath.
// Buffers ALU result words in a small FIFO and drains one word per cycle into
// the X, R or P vector memory, pulsing read_again / read_again_2 so operand
// fetch can advance. A phase writes total/NO_OF_UNITS words and then pulses
// phase_done.
//
// Optional build macro: CG_WB_PERF_CNT_EN
//   defined   -> stall_cycles counts WRITE cycles with buffered data but
//                mem_ready low (saturating, cleared by reset only).
//   undefined -> stall_cycles is tied to zero.
module cg_result_writeback #(
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           total,
    input  logic                  phase_start,
    input  logic [1:0]            phase_sel,
    input  logic                  abort,
    cg_result_writeback_if.master wb,
    output logic                  busy,
    output logic                  phase_done,
    output logic                  error,
    output logic [31:0]           stall_cycles,
    output logic [1:0]            dbg_state
);
    localparam int W  = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = FIFO_DEPTH[PW:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;

    // Result buffer
    logic [W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            fifo_full;
    logic            fifo_empty;

    // Phase bookkeeping
    logic [31:0]     words;
    logic [31:0]     accepted;
    logic [31:0]     write_idx;
    logic [1:0]      sel_q;
    logic [31:0]     start_words;

    // Registered write-port outputs
    logic [W-1:0]    wdata_q;
    logic [31:0]     waddr_q;
    logic            we_x_q;
    logic            we_r_q;
    logic            we_p_q;
    logic            ra_q;
    logic            ra2_q;

    logic            alu_ready_int;
    logic            push;
    logic            pop;
    logic            last_pop;

    // Word count of the requested phase; a remainder below one word is dropped.
    assign start_words = total / 32'(NO_OF_UNITS);

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // Only accept as many beats as the phase will write, so the FIFO is always
    // empty again once the last word has gone out.
    assign alu_ready_int = (state == S_WRITE) && !fifo_full && (accepted < words);
    assign push          = wb.alu_valid && alu_ready_int;
    assign pop           = (state == S_WRITE) && !fifo_empty && wb.mem_ready;
    assign last_pop      = pop && (write_idx == words - 32'd1);

    assign wb.alu_ready    = alu_ready_int;
    assign wb.mem_wdata    = wdata_q;
    assign wb.mem_waddr    = waddr_q;
    assign wb.mem_we_x     = we_x_q;
    assign wb.mem_we_r     = we_r_q;
    assign wb.mem_we_p     = we_p_q;
    assign wb.read_again   = ra_q;
    assign wb.read_again_2 = ra2_q;

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Buffer storage: data only, no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wb.alu_data;
        end
    end

    // Buffer pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Phase sequencer with registered write strobes, addresses and status.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state     <= S_IDLE;
            words     <= '0;
            accepted  <= '0;
            write_idx <= '0;
            sel_q     <= 2'd0;
            wdata_q   <= '0;
            waddr_q   <= '0;
            we_x_q    <= 1'b0;
            we_r_q    <= 1'b0;
            we_p_q    <= 1'b0;
            ra_q      <= 1'b0;
            ra2_q     <= 1'b0;
            phase_done <= 1'b0;
            error     <= 1'b0;
        end else begin
            // Strobes and pulses are single-cycle unless re-armed below.
            we_x_q     <= 1'b0;
            we_r_q     <= 1'b0;
            we_p_q     <= 1'b0;
            ra_q       <= 1'b0;
            ra2_q      <= 1'b0;
            phase_done <= 1'b0;

            if (push) begin
                accepted <= accepted + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (phase_start) begin
                        if (phase_sel == 2'd3) begin
                            error <= 1'b1;
                        end else begin
                            error     <= 1'b0;
                            sel_q     <= phase_sel;
                            words     <= start_words;
                            accepted  <= '0;
                            write_idx <= '0;
                            waddr_q   <= '0;
                            state     <= (start_words == '0) ? S_DONE : S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (phase_start) begin
                        error <= 1'b1;
                    end
                    if (pop) begin
                        wdata_q   <= fifo_mem[rd_ptr];
                        waddr_q   <= write_idx;
                        write_idx <= write_idx + 32'd1;
                        case (sel_q)
                            2'd0: begin
                                we_x_q <= 1'b1;
                                ra_q   <= 1'b1;
                            end
                            2'd1: begin
                                we_r_q <= 1'b1;
                            end
                            default: begin
                                we_p_q <= 1'b1;
                                ra2_q  <= 1'b1;
                            end
                        endcase
                        // Completion is flagged alongside the strobe of the final write.
                        if (last_pop) begin
                            phase_done <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (phase_start) begin
                        error <= 1'b1;
                    end
                    // phase_done already high means it coincided with the last
                    // write; otherwise this was a zero-word phase and it is
                    // raised now, one cycle after entry.
                    if (phase_done) begin
                        state <= S_IDLE;
                    end else begin
                        phase_done <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CG_WB_PERF_CNT_EN
    logic [31:0] stall_q;

    // Backpressure counter: survives abort so stalls accumulate across phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == S_WRITE) && !fifo_empty && !wb.mem_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cg_result_writeback.sv
// Testbench for cg_result_writeback: a table of phases plus random phases,
// each checked cycle by cycle against a word-level model of the phase
// (buffer occupancy, expected write order, completion timing), followed by
// hand-written illegal-request, reset and abort sequences.
module tb_cg_result_writeback;
    localparam int NO_OF_UNITS   = 8;
    localparam int ELEMENT_WIDTH = 32;
    localparam int FIFO_DEPTH    = 4;
    localparam int W  = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam int CW = (W > 32) ? W : 32;

    typedef struct {
        logic [1:0]  sel;
        int unsigned tot;
        int          ready_pct;   // <0 selects the scripted 5-cycle stall
        int          valid_pct;
        int          inject_at;   // cycle of an illegal phase_start, <0 none
        int          exp_writes;
        logic        exp_err;
        int          exp_stall;   // <0 uses the model's stall count
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] total;
    logic        phase_start;
    logic [1:0]  phase_sel;
    logic        abort;
    logic        busy;
    logic        phase_done;
    logic        error;
    logic [31:0] stall_cycles;
    logic [1:0]  dbg_state;

    int checks;
    int errors;

    cg_result_writeback_if #(.NO_OF_UNITS(NO_OF_UNITS), .ELEMENT_WIDTH(ELEMENT_WIDTH)) wb();

    cg_result_writeback #(
        .NO_OF_UNITS(NO_OF_UNITS),
        .ELEMENT_WIDTH(ELEMENT_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .total(total),
        .phase_start(phase_start),
        .phase_sel(phase_sel),
        .abort(abort),
        .wb(wb),
        .busy(busy),
        .phase_done(phase_done),
        .error(error),
        .stall_cycles(stall_cycles),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) begin
            v = (v << 32) | W'($urandom);
        end
        return v;
    endfunction

    function automatic int n_strobes();
        return int'(wb.mem_we_x) + int'(wb.mem_we_r) + int'(wb.mem_we_p);
    endfunction

    // Drive the bus inputs for cycle k of a phase.
    task automatic drive(input vec_t v, input int k, input logic [W-1:0] word);
        wb.alu_valid = ($urandom_range(99) < v.valid_pct);
        wb.alu_data  = word;
        if (v.ready_pct < 0) begin
            wb.mem_ready = !(k >= 3 && k <= 7);
        end else begin
            wb.mem_ready = ($urandom_range(99) < v.ready_pct);
        end
        phase_start = (k == v.inject_at);
        if (k == v.inject_at) begin
            phase_sel = 2'd1;
            total     = 32'd64;
        end
    endtask

    // Run one phase from its start pulse until the cycle after phase_done.
    // Called and returns just after a rising edge.
    task automatic run_phase(input vec_t v, output int n_wr, output int model_stall);
        logic [W-1:0] data[$];
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_word;
        int  words;
        int  acc;
        int  wr;
        int  occ;
        int  cyc;
        bit  exp_pop;
        bit  exp_done;
        bit  done_seen;
        bit  finished;

        words = int'(v.tot / NO_OF_UNITS);
        for (int i = 0; i < words + 4; i++) data.push_back(rand_word());
        for (int i = 0; i < words; i++) exp_q.push_back(data[i]);
        acc = 0; wr = 0; n_wr = 0; model_stall = 0;
        exp_pop = 1'b0; done_seen = 1'b0; finished = 1'b0;

        phase_start  = 1'b1;
        phase_sel    = v.sel;
        total        = v.tot;
        wb.alu_valid = 1'b0;
        wb.mem_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble the sampled inputs to show they were latched.
        phase_sel = 2'($urandom);
        total     = $urandom;
        drive(v, 0, data[0]);

        for (cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk);
            n_wr += n_strobes();
            check("strobe_timing", (n_strobes() != 0), exp_pop);
            if (exp_pop) begin
                if (exp_q.size() == 0) begin
                    fail("write_beyond_words");
                end else begin
                    exp_word = exp_q.pop_front();
                    check("we_x", wb.mem_we_x, (v.sel == 2'd0));
                    check("we_r", wb.mem_we_r, (v.sel == 2'd1));
                    check("we_p", wb.mem_we_p, (v.sel == 2'd2));
                    check("waddr", wb.mem_waddr, wr);
                    check("wdata", wb.mem_wdata, exp_word);
                end
                wr++;
            end
            check("read_again", wb.read_again, (exp_pop && v.sel == 2'd0));
            check("read_again_2", wb.read_again_2, (exp_pop && v.sel == 2'd2));
            exp_done = (words > 0) ? (exp_pop && wr == words) : (cyc == 1);
            check("phase_done", phase_done, exp_done);
            check("busy", busy, !done_seen);
            check("error", error, (v.inject_at >= 0 && cyc > v.inject_at));
            if (done_seen) finished = 1'b1;
            if (exp_done) done_seen = 1'b1;

            occ = acc - wr;
            check("alu_ready", wb.alu_ready, (occ < FIFO_DEPTH && acc < words));
            if (v.ready_pct < 0 && cyc == 7) check("stall_fifo_full", wb.alu_ready, 1'b0);
            if (occ > 0 && !wb.mem_ready) model_stall++;
            exp_pop = (occ > 0) && wb.mem_ready;
            if (wb.alu_valid && wb.alu_ready) acc++;

            if (!finished) begin
                @(posedge clk); #1;
                drive(v, cyc + 1, data[acc]);
            end
        end
        if (!finished) fail("phase_timeout");
        wb.alu_valid = 1'b0;
        phase_start  = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t vecs[8];
    vec_t rv;
    int   n_wr;
    int   mstall;
    logic [31:0] st0;
    int   seen;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; abort = 1'b0; phase_start = 1'b0; phase_sel = 2'd0; total = '0;
        wb.alu_valid = 1'b0; wb.alu_data = '0; wb.mem_ready = 1'b0;

        //             sel    tot rdy  vld  inj wr err stall
        vecs[0] = '{2'd0, 32, 100, 100, -1, 4, 1'b0, -1};
        vecs[1] = '{2'd2, 24, 100, 100, -1, 3, 1'b0, -1};
        vecs[2] = '{2'd1, 64,  -1, 100, -1, 8, 1'b0,  5};
        vecs[3] = '{2'd0,  7, 100, 100, -1, 0, 1'b0, -1};
        vecs[4] = '{2'd1, 32, 100, 100,  2, 4, 1'b1, -1};
        vecs[5] = '{2'd2, 40,  50,  70, -1, 5, 1'b0, -1};
        vecs[6] = '{2'd0,  8,  30, 100, -1, 1, 1'b0, -1};
        vecs[7] = '{2'd1, 31,  60,  40, -1, 3, 1'b0, -1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", phase_done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_strobes", n_strobes(), 0);
        check("rst_waddr", wb.mem_waddr, 32'd0);
        check("rst_wdata", wb.mem_wdata, '0);
        check("rst_alu_ready", wb.alu_ready, 1'b0);
        check("rst_stall", stall_cycles, 32'd0);
        @(posedge clk); #1;

        // Illegal phase_sel: error, no activity
        phase_start = 1'b1; phase_sel = 2'd3; total = 32'd32;
        @(posedge clk); #1;
        phase_start = 1'b0; wb.alu_valid = 1'b1; wb.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("illegal_error", error, 1'b1);
            check("illegal_busy", busy, 1'b0);
            check("illegal_ready", wb.alu_ready, 1'b0);
            check("illegal_strobes", n_strobes(), 0);
        end
        @(posedge clk); #1;
        wb.alu_valid = 1'b0;

        // Table-driven phases
        for (int i = 0; i < 8; i++) begin
            st0 = stall_cycles;
            run_phase(vecs[i], n_wr, mstall);
            check("tbl_writes", n_wr, vecs[i].exp_writes);
            check("tbl_error_end", error, vecs[i].exp_err);
`ifdef CG_WB_PERF_CNT_EN
            check("tbl_stall", stall_cycles - st0, (vecs[i].exp_stall >= 0) ? vecs[i].exp_stall : mstall);
`else
            check("tbl_stall_tied", stall_cycles, 32'd0);
`endif
        end

        // Random phases
        for (int i = 0; i < 12; i++) begin
            rv.sel        = 2'($urandom_range(2));
            rv.tot        = $urandom_range(80);
            rv.ready_pct  = $urandom_range(100, 20);
            rv.valid_pct  = $urandom_range(100, 20);
            rv.inject_at  = -1;
            rv.exp_writes = int'(rv.tot / NO_OF_UNITS);
            rv.exp_err    = 1'b0;
            rv.exp_stall  = -1;
            st0 = stall_cycles;
            run_phase(rv, n_wr, mstall);
            check("rnd_writes", n_wr, rv.exp_writes);
`ifdef CG_WB_PERF_CNT_EN
            check("rnd_stall", stall_cycles - st0, mstall);
`else
            check("rnd_stall_tied", stall_cycles, 32'd0);
`endif
        end

        // Abort after two of four X writes
        phase_start = 1'b1; phase_sel = 2'd0; total = 32'd32;
        @(posedge clk); #1;
        phase_start = 1'b0; wb.alu_valid = 1'b1; wb.alu_data = rand_word(); wb.mem_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 50 && seen < 2; c++) begin
            @(negedge clk);
            seen += n_strobes();
            if (seen < 2) begin
                @(posedge clk); #1;
            end
        end
        if (seen < 2) fail("abort_wait_writes");
        @(posedge clk); #1;
        st0 = stall_cycles;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_strobes", n_strobes(), 0);
            check("abort_busy", busy, 1'b0);
            check("abort_done", phase_done, 1'b0);
            check("abort_ra", {wb.read_again, wb.read_again_2}, 2'b00);
            check("abort_alu_ready", wb.alu_ready, 1'b0);
            if (i == 0) check("abort_waddr", wb.mem_waddr, 32'd0);
            check("abort_stall_kept", stall_cycles, st0);
        end
        @(posedge clk); #1;
        wb.alu_valid = 1'b0;
        run_phase(vecs[0], n_wr, mstall);
        check("post_abort_writes", n_wr, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
